// File: rtl/shuffle_sched.sv
// rtl/shuffle_sched.sv - layer/slot walker feeding the shuffle ROM into a one-entry output register
// Optional feature macro: SHUFFLE_OFFSET_EN (per-pass seed rotation of slot order).
module shuffle_sched #(
    parameter int LAYERS = 8,
    parameter int SLOTS  = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       inverse,
    input  logic [4:0] seed,
    input  logic       layer_go,
    output logic [7:0] rom_old_addr,
    input  logic [5:0] rom_new_addr,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [5:0] out_addr,
    output logic [2:0] out_layer,
    output logic       out_last,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, RUN, WAIT_LAYER, FLUSH} state_t;

    localparam logic [2:0] LAST_LAYER = 3'(LAYERS - 1);
    localparam logic [4:0] LAST_SLOT  = 5'(SLOTS - 1);

    state_t     state, state_nxt;
    logic [2:0] layer;
    logic [4:0] cnt;
    logic [4:0] offset;
    logic [4:0] slot;
    logic       inv_r;
    logic       ld;
    logic       go_next;
    logic       finish;
    logic       final_layer;

    assign slot         = cnt + offset;
    assign rom_old_addr = {layer, slot};
    assign busy         = (state != IDLE);
    assign final_layer  = inv_r ? (layer == 3'd0) : (layer == LAST_LAYER);

    always_comb begin
        state_nxt = state;
        ld        = 1'b0;
        go_next   = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                ld = !out_valid || out_ready;
                if (ld && cnt == LAST_SLOT) state_nxt = final_layer ? FLUSH : WAIT_LAYER;
            end
            WAIT_LAYER: begin
                // layer_go only counts once the last index of the layer has drained
                if (!out_valid && layer_go) begin
                    go_next   = 1'b1;
                    state_nxt = RUN;
                end
            end
            FLUSH: begin
                if (!out_valid || out_ready) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            layer     <= 3'd0;
            cnt       <= 5'd0;
            inv_r     <= 1'b0;
            out_valid <= 1'b0;
            out_addr  <= 6'd0;
            out_layer <= 3'd0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= finish;
            if (state == IDLE && start) begin
                inv_r <= inverse;
                layer <= inverse ? LAST_LAYER : 3'd0;
                cnt   <= 5'd0;
            end
            if (go_next) begin
                layer <= inv_r ? layer - 3'd1 : layer + 3'd1;
                cnt   <= 5'd0;
            end
            if (ld) begin
                out_addr  <= rom_new_addr;
                out_layer <= layer;
                out_last  <= (cnt == LAST_SLOT);
                out_valid <= 1'b1;
                cnt       <= cnt + 5'd1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef SHUFFLE_OFFSET_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            offset <= 5'd0;
        end else if (state == IDLE && start) begin
            offset <= seed;
        end
    end
`else
    logic unused_seed;
    assign unused_seed = ^seed;
    assign offset      = 5'd0;
`endif

endmodule

// File: tb/tb_shuffle_sched.sv
// tb/tb_shuffle_sched.sv - scoreboard bench for shuffle_sched with a modelled shuffle ROM
module tb_shuffle_sched;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       inverse = 1'b0;
    logic [4:0] seed = 5'd0;
    logic       layer_go = 1'b1;
    logic [7:0] rom_old_addr;
    logic [5:0] rom_new_addr;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [5:0] out_addr;
    logic [2:0] out_layer;
    logic       out_last;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_pass   = 0;
    int hs_cnt   = 0;
    int done_cnt = 0;
    int exp_q[$];
    int pop_log[$];

`ifdef SHUFFLE_OFFSET_EN
    localparam bit OFFSET_EN = 1'b1;
`else
    localparam bit OFFSET_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    shuffle_sched dut (
        .clk(clk), .rst(rst), .start(start), .inverse(inverse), .seed(seed),
        .layer_go(layer_go), .rom_old_addr(rom_old_addr), .rom_new_addr(rom_new_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_layer(out_layer), .out_last(out_last), .busy(busy), .done(done)
    );

    // Shuffle ROM stand-in: hand-pinned entries used by the directed checks, hash elsewhere
    function automatic logic [5:0] rom_f(input logic [7:0] a);
        logic [7:0] t;
        t = a * 8'd37 + 8'd13;
        case (a)
            8'd0:    return 6'd18;
            8'd1:    return 6'd3;
            8'd4:    return 6'd27;
            8'd5:    return 6'd26;
            8'd31:   return 6'd1;
            8'd32:   return 6'd8;
            8'd224:  return 6'd48;
            default: return t[5:0] ^ a[7:2];
        endcase
    endfunction

    assign rom_new_addr = rom_f(rom_old_addr);

    function automatic int pack(input int l, input int last, input int a);
        return (l << 7) | (last << 6) | a;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            hs_cnt++;
            pop_log.push_back(pack(out_layer, out_last, out_addr));
            if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
            else chk("sb_entry", pack(out_layer, out_last, out_addr), exp_q.pop_front());
        end
        if (done) begin
            done_cnt++;
            chk("busy_in_done_cycle", busy, 0);
        end
    end

    task automatic push_pass(input logic inv, input logic [4:0] sd);
        int l;
        logic [4:0] s;
        for (int li = 0; li < 8; li++) begin
            l = inv ? 7 - li : li;
            for (int c = 0; c < 32; c++) begin
                s = 5'(c) + (OFFSET_EN ? sd : 5'd0);
                exp_q.push_back(pack(l, (c == 31) ? 1 : 0, rom_f({3'(l), s})));
            end
        end
    endtask

    task automatic do_start(input logic inv, input logic [4:0] sd);
        pop_log.delete();
        push_pass(inv, sd);
        @(posedge clk); #1;
        start = 1'b1; inverse = inv; seed = sd;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int hs0);
        int d0;
        bit seen;
        d0 = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(posedge clk);
            if (done_cnt != d0) seen = 1'b1;
        end
        chk({name, "_done_seen"}, seen, 1);
        repeat (4) @(posedge clk);
        #1;
        chk({name, "_done_once"}, done_cnt - d0, 1);
        chk({name, "_handshakes"}, hs_cnt - hs0, 256);
        chk({name, "_sb_empty"}, exp_q.size(), 0);
        chk({name, "_idle"}, busy, 0);
    endtask

    initial begin
        int hs0;
        int d0;
        bit seen;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {out_valid, out_addr, out_layer, out_last, busy, done, rom_old_addr}, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_after_reset", {busy, out_valid}, 0);

        // Forward pass, full throughput
        hs0 = hs_cnt;
        do_start(1'b0, 5'd0);
        chk("fwd_rom_first", rom_old_addr, 0);
        chk("fwd_busy", busy, 1);
        chk("fwd_valid_latency", out_valid, 0);
        @(posedge clk); #1;
        chk("fwd_first_valid", out_valid, 1);
        wait_done("fwd", hs0);
        chk("fwd_first_idx", pop_log[0], 18);
        chk("fwd_layer1_first", pop_log[32], pack(1, 0, 8));

        // Inverse pass
        hs0 = hs_cnt;
        do_start(1'b1, 5'd0);
        chk("inv_rom_first", rom_old_addr, 224);
        wait_done("inv", hs0);
        chk("inv_first_idx", pop_log[0], pack(7, 0, 48));
        chk("inv_last_idx", pop_log[255], pack(0, 1, 1));

        // Backpressure at the first index
        out_ready = 1'b0;
        hs0 = hs_cnt;
        do_start(1'b0, 5'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold", {out_valid, out_addr}, {1'b1, 6'd18});
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_next_idx", {out_valid, out_addr}, {1'b1, 6'd3});
        wait_done("bp", hs0);

        // layer_go held low stalls after the first layer
        layer_go = 1'b0;
        hs0 = hs_cnt;
        do_start(1'b0, 5'd0);
        repeat (60) @(posedge clk);
        #1;
        chk("stall_handshakes", hs_cnt - hs0, 32);
        chk("stall_valid", out_valid, 0);
        chk("stall_busy", busy, 1);
        layer_go = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("resume_seen", seen, 1);
        chk("resume_layer", out_layer, 1);
        wait_done("stall", hs0);

        // Seed rotation (ignored when the offset feature is compiled out)
        hs0 = hs_cnt;
        do_start(1'b0, 5'd5);
        chk("seed_rom_first", rom_old_addr, OFFSET_EN ? 5 : 0);
        wait_done("seed", hs0);
        chk("seed_first_idx", pop_log[0], OFFSET_EN ? 26 : 18);
        chk("seed_slot31_idx", pop_log[31], OFFSET_EN ? pack(0, 1, 27) : pack(0, 1, 1));

        // Asynchronous reset in the middle of layer 3
        do_start(1'b0, 5'd0);
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(posedge clk); #1;
            if (out_valid && out_layer == 3'd3) seen = 1'b1;
        end
        chk("reach_layer3", seen, 1);
        d0 = done_cnt;
        #2 rst = 1'b1;
        #1;
        chk("midrst_outputs", {out_valid, out_addr, out_layer, out_last, busy, done, rom_old_addr}, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_no_done", done_cnt - d0, 0);
        chk("midrst_idle", {busy, out_valid}, 0);
        hs0 = hs_cnt;
        do_start(1'b0, 5'd0);
        chk("restart_rom_first", rom_old_addr, 0);
        wait_done("restart", hs0);
        chk("restart_first_idx", pop_log[0], 18);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
